// File: rtl/tft_bus_arbiter.sv
// Request/grant arbiter sharing one tft_spi byte transmitter among N requesters.
// Optional round-robin selection is enabled by defining TFT_ARB_ROUND_ROBIN_EN.
module tft_bus_arbiter #(
    parameter int N          = 3,
    parameter int GAP_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic [8*N-1:0]   req_data,
    input  logic [N-1:0]     req_dc,
    input  logic [N-1:0]     req_transmit,
    output logic [N-1:0]     req_busy,
    output logic [N-1:0]     grant,
    output logic [7:0]       spi_data,
    output logic             spi_dc,
    output logic             spi_transmit,
    input  logic             spi_busy,
    output logic             tft_cs,
    output logic             arb_idle
);

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int CNT_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : {CNT_W{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2,
        ST_GAP     = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [N-1:0]       r_grant;
    logic [N-1:0]       w_grant_nxt;
    logic [IDX_W-1:0]   r_owner;
    logic [IDX_W-1:0]   w_owner_nxt;
    logic [CNT_W-1:0]   r_gap_cnt;
    logic [CNT_W-1:0]   w_gap_cnt_nxt;
    logic               r_tft_cs;
    logic               w_tft_cs_nxt;
    logic [IDX_W-1:0]   w_win;
    logic               w_any;

    assign w_any = |req;

`ifdef TFT_ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0]   r_last;
    logic [IDX_W-1:0]   w_probe;
    logic               w_found;

    // Round-robin search starting just after the last winner
    always_comb begin
        w_win   = {IDX_W{1'b0}};
        w_probe = {IDX_W{1'b0}};
        w_found = 1'b0;
        for (int k = 0; k < N; k++) begin
            w_probe = IDX_W'((int'(r_last) + 1 + k) % N);
            if (!w_found && req[w_probe]) begin
                w_found = 1'b1;
                w_win   = w_probe;
            end else begin
                w_found = w_found;
            end
        end
    end

    // Remember the last winner whenever a grant is issued
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last <= IDX_W'(N - 1);
        end else if (r_state == ST_IDLE && w_any) begin
            r_last <= w_win;
        end
    end
`else
    // Fixed priority: lowest requesting index wins
    always_comb begin
        w_win = {IDX_W{1'b0}};
        for (int k = N - 1; k >= 0; k--) begin
            if (req[k]) begin
                w_win = IDX_W'(k);
            end else begin
                w_win = w_win;
            end
        end
    end
`endif

    // Next-state logic; grant and chip select are precomputed so they leave flops
    always_comb begin
        w_state_nxt   = r_state;
        w_grant_nxt   = r_grant;
        w_owner_nxt   = r_owner;
        w_gap_cnt_nxt = r_gap_cnt;
        w_tft_cs_nxt  = r_tft_cs;
        case (r_state)
            ST_IDLE: begin
                w_grant_nxt  = {N{1'b0}};
                w_tft_cs_nxt = 1'b1;
                if (w_any) begin
                    w_state_nxt  = ST_GRANT;
                    w_grant_nxt  = N'(1'b1) << w_win;
                    w_owner_nxt  = w_win;
                    w_tft_cs_nxt = 1'b0;
                end else begin
                    w_state_nxt  = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (!req[r_owner]) begin
                    w_state_nxt = ST_RELEASE;
                end else begin
                    w_state_nxt = ST_GRANT;
                end
            end
            ST_RELEASE: begin
                // Keep the bus until the last byte has fully left tft_spi
                if (!spi_busy) begin
                    w_grant_nxt  = {N{1'b0}};
                    w_tft_cs_nxt = 1'b1;
                    if (GAP_CYCLES > 0) begin
                        w_state_nxt   = ST_GAP;
                        w_gap_cnt_nxt = GAP_LOAD;
                    end else begin
                        w_state_nxt   = ST_IDLE;
                    end
                end else begin
                    w_state_nxt = ST_RELEASE;
                end
            end
            ST_GAP: begin
                if (r_gap_cnt == {CNT_W{1'b0}}) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt - CNT_W'(1'b1);
                end
            end
            default: begin
                w_state_nxt   = ST_IDLE;
                w_grant_nxt   = {N{1'b0}};
                w_tft_cs_nxt  = 1'b1;
                w_gap_cnt_nxt = {CNT_W{1'b0}};
            end
        endcase
    end

    // State and registered-output flops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_grant   <= {N{1'b0}};
            r_owner   <= {IDX_W{1'b0}};
            r_gap_cnt <= {CNT_W{1'b0}};
            r_tft_cs  <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_grant   <= w_grant_nxt;
            r_owner   <= w_owner_nxt;
            r_gap_cnt <= w_gap_cnt_nxt;
            r_tft_cs  <= w_tft_cs_nxt;
        end
    end

    // Owner's byte passes straight through; strobes only while the burst is live
    always_comb begin
        spi_data     = 8'd0;
        spi_dc       = 1'b0;
        spi_transmit = 1'b0;
        if (r_state == ST_GRANT || r_state == ST_RELEASE) begin
            spi_data     = req_data[{r_owner, 3'b000} +: 8];
            spi_dc       = req_dc[r_owner];
            spi_transmit = (r_state == ST_GRANT) && req[r_owner] && req_transmit[r_owner];
        end else begin
            spi_data     = 8'd0;
        end
    end

    assign grant    = r_grant;
    assign tft_cs   = r_tft_cs;
    assign req_busy = ~r_grant | (r_grant & {N{spi_busy}});
    assign arb_idle = (r_state == ST_IDLE) && !w_any;

endmodule

// File: tb/tb_tft_bus_arbiter.sv
// Randomized bench for tft_bus_arbiter against a burst-level reference model.
module tb_tft_bus_arbiter;

    localparam int N   = 3;
    localparam int GAP = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req;
    logic [8*N-1:0]   req_data;
    logic [N-1:0]     req_dc;
    logic [N-1:0]     req_transmit;
    logic [N-1:0]     req_busy;
    logic [N-1:0]     grant;
    logic [7:0]       spi_data;
    logic             spi_dc;
    logic             spi_transmit;
    logic             spi_busy;
    logic             tft_cs;
    logic             arb_idle;

    always #5 clk = ~clk;

    tft_bus_arbiter #(.N(N), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_dc(req_dc),
        .req_transmit(req_transmit), .req_busy(req_busy), .grant(grant),
        .spi_data(spi_data), .spi_dc(spi_dc), .spi_transmit(spi_transmit),
        .spi_busy(spi_busy), .tft_cs(tft_cs), .arb_idle(arb_idle)
    );

    int checks = 0;
    int errors = 0;

    // reference model: who owns the bus, whether it is draining, gap cycles left
    int m_owner;
    int m_gap_left;
    int m_last;
    bit m_drain;

    // requester agents and tft_spi emulation
    bit [N-1:0] a_req;
    int         a_left [N];
    bit [N-1:0] a_tx;
    bit [7:0]   a_data [N];
    bit [N-1:0] a_dc;
    bit [N-1:0] raise_mask;
    bit         use_tab;
    bit         stray_en;
    bit         rst_nxt;
    bit         prev_tx;
    int         busy_left;
    int         busy_max;
    logic [7:0] byte_tab [3];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner    = -1;
        m_gap_left = 0;
        m_last     = N - 1;
        m_drain    = 1'b0;
    endtask

    function automatic int pick(input logic [N-1:0] r);
`ifdef TFT_ARB_ROUND_ROBIN_EN
        for (int k = 1; k <= N; k++) begin
            if (r[(m_last + k) % N]) return (m_last + k) % N;
        end
`else
        for (int j = 0; j < N; j++) begin
            if (r[j]) return j;
        end
`endif
        return -1;
    endfunction

    task automatic model_step(input logic [N-1:0] r, input logic b, input logic rs);
        if (rs) begin
            model_reset();
        end else if (m_owner >= 0) begin
            if (!m_drain) begin
                if (!r[m_owner]) m_drain = 1'b1;
            end else if (!b) begin
                m_owner    = -1;
                m_drain    = 1'b0;
                m_gap_left = GAP;
            end
        end else if (m_gap_left > 0) begin
            m_gap_left--;
        end else if (r != '0) begin
            m_owner = pick(r);
            m_last  = m_owner;
        end
    endtask

    task automatic check_outputs();
        logic [N-1:0] eg;
        logic [N-1:0] eb;
        logic [7:0]   ed;
        logic         edc;
        logic         etx;
        eg  = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
        ed  = (m_owner >= 0) ? req_data[8*m_owner +: 8] : 8'h00;
        edc = (m_owner >= 0) ? req_dc[m_owner] : 1'b0;
        etx = (m_owner >= 0) && !m_drain && req[m_owner] && req_transmit[m_owner];
        eb  = ~eg | (eg & {N{spi_busy}});
        check_val("grant",        32'(grant),        32'(eg));
        check_val("tft_cs",       32'(tft_cs),       32'(m_owner < 0));
        check_val("spi_data",     32'(spi_data),     32'(ed));
        check_val("spi_dc",       32'(spi_dc),       32'(edc));
        check_val("spi_transmit", 32'(spi_transmit), 32'(etx));
        check_val("req_busy",     32'(req_busy),     32'(eb));
        check_val("arb_idle",     32'(arb_idle),
                  32'(m_owner < 0 && m_gap_left == 0 && req == '0));
        prev_tx = etx;
    endtask

    task automatic drive_agents();
        for (int i = 0; i < N; i++) begin
            a_tx[i]   = 1'b0;
            a_data[i] = 8'($urandom);
            a_dc[i]   = 1'($urandom);
            if (!a_req[i]) begin
                if (raise_mask[i] && $urandom_range(0, 3) == 0) begin
                    a_req[i]  = 1'b1;
                    a_left[i] = $urandom_range(1, 3);
                end
            end else if (m_owner == i && !m_drain) begin
                if (a_left[i] == 0) begin
                    a_req[i] = 1'b0;
                    a_tx[i]  = 1'($urandom_range(0, 1));
                end else if (busy_left == 0 && $urandom_range(0, 1) == 1) begin
                    a_tx[i] = 1'b1;
                    if (use_tab) a_data[i] = byte_tab[3 - a_left[i]];
                    a_left[i]--;
                end
            end
            if (!(m_owner == i && !m_drain) && stray_en && $urandom_range(0, 3) == 0) a_tx[i] = 1'b1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step(req, spi_busy, rst);
        if (rst) busy_left = 0;
        else if (prev_tx) busy_left = $urandom_range(1, busy_max);
        else if (busy_left > 0) busy_left--;
        #1;
        if (rst_nxt) begin
            a_req = '0;
            a_tx  = '0;
        end else begin
            drive_agents();
        end
        rst          = rst_nxt;
        req          = a_req;
        req_transmit = a_tx;
        req_dc       = a_dc;
        for (int i = 0; i < N; i++) req_data[8*i +: 8] = a_data[i];
        spi_busy     = (busy_left > 0);
        #3;
        check_outputs();
    endtask

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        while (!(m_owner < 0 && m_gap_left == 0 && req == '0) && n < bound) begin
            step();
            n++;
        end
        if (n >= bound) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: still busy after %0d cycles", bound);
        end
    endtask

    initial begin
        bit done_arst;
        byte_tab[0] = 8'h2A;
        byte_tab[1] = 8'h00;
        byte_tab[2] = 8'hEF;
        rst = 1'b1; rst_nxt = 1'b1;
        req = '0; req_data = '0; req_dc = '0; req_transmit = '0; spi_busy = 1'b0;
        a_req = '0; a_tx = '0; a_dc = '0; raise_mask = '0;
        for (int i = 0; i < N; i++) a_left[i] = 0;
        use_tab = 1'b0; stray_en = 1'b0; prev_tx = 1'b0; busy_left = 0; busy_max = 4;
        done_arst = 1'b0;
        model_reset();

        repeat (3) step();
        rst_nxt = 1'b0;
        repeat (4) step();
        check_val("idle_after_reset", 32'(arb_idle), 32'd1);

        // single burst from requester 1 with fixed bytes
        use_tab = 1'b1; a_req = 3'b010; a_left[1] = 3;
        step();
        check_val("burst_pre_grant", 32'(grant), 32'd0);
        step();
        check_val("burst_grant", 32'(grant), 32'b010);
        check_val("burst_cs",    32'(tft_cs), 32'd0);
        wait_idle(200);
        use_tab = 1'b0;

        // all three request together, stray strobes from the losers
        stray_en = 1'b1; a_req = 3'b111;
        for (int i = 0; i < N; i++) a_left[i] = $urandom_range(1, 3);
        step();
        step();
        check_val("contention_grant", 32'(grant), 32'(pick(3'b111) >= 0 ? (N'(1) << pick(3'b111)) : 0));
        wait_idle(300);

        // long drain on requester 0 while requester 2 waits
        busy_max = 6; a_req = 3'b001; a_left[0] = 1;
        for (int n = 0; n < 100 && !m_drain; n++) step();
        a_req[2] = 1'b1; a_left[2] = 1;
        wait_idle(300);
        busy_max = 4;

        // randomized traffic with one asynchronous mid-burst reset
        raise_mask = '1;
        for (int c = 0; c < 2000; c++) begin
            step();
            if (!done_arst && c > 300 && m_owner >= 0 && spi_busy) begin
                rst = 1'b1;
                #1;
                check_val("arst_grant", 32'(grant),  32'd0);
                check_val("arst_cs",    32'(tft_cs), 32'd1);
                model_reset();
                a_req = '0;
                for (int i = 0; i < N; i++) a_left[i] = 0;
                busy_left = 0;
                rst_nxt   = 1'b1;
                done_arst = 1'b1;
                step();
                step();
                rst_nxt = 1'b0;
            end
        end
        raise_mask = '0;
        wait_idle(300);
        check_val("final_idle", 32'(arb_idle), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
